// File: rtl/tick_delay_timer_pkg.sv
// Purpose : shared types and constants for the tick-driven one-shot delay timer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_e        - FSM state encoding shared by RTL and bench
//   TB_*           - bit positions of the tick-enable strobes on tick_i
//   DEF_CNT_WIDTH  - default width of the delay counter
package tick_delay_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Position of each time base on the tick_i bus
  localparam int TB_1US  = 0;
  localparam int TB_10US = 1;
  localparam int TB_1MS  = 2;
  localparam int TB_1S   = 3;

  localparam int DEF_CNT_WIDTH = 16;

endpackage : tick_delay_timer_pkg

// File: rtl/tick_delay_timer.sv
// Purpose : one-shot delay timer counting a selectable tick-enable strobe; done pulse + sticky expired flag.
// Latency : done_o rises the cycle after the terminal tick; delay==0 start gives done_o the next cycle.
// Backpressure: none; start_i/stop_i are always accepted (stop wins over a coincident start).
//
// Ports:
//   clk        in   system clock (2MHz domain)
//   nrst       in   asynchronous active-low reset
//   tick_i     in   NUM_TB one-cycle tick enables (bit0=1us, bit1=10us, bit2=1ms, bit3=1s)
//   start_i    in   one-cycle request, captures tb_sel_i and delay_i
//   stop_i     in   one-cycle cancel
//   tb_sel_i   in   time-base index into tick_i
//   delay_i    in   delay in selected ticks
//   busy_o     out  high while arming or counting
//   done_o     out  one-cycle expiry pulse
//   expired_o  out  sticky expiry flag, cleared by start_i or stop_i
//   remain_o   out  ticks still to count
module tick_delay_timer
  import tick_delay_timer_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int NUM_TB       = 4,
  parameter int TB_SEL_WIDTH = 2,
  parameter bit ALIGN        = 1'b1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_TB-1:0]       tick_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [TB_SEL_WIDTH-1:0] tb_sel_i,
  input  logic [CNT_WIDTH-1:0]    delay_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    expired_o,
  output logic [CNT_WIDTH-1:0]    remain_o
);

  state_e                  state_q,   state_d;
  logic [TB_SEL_WIDTH-1:0] tb_sel_q,  tb_sel_d;
  logic [CNT_WIDTH-1:0]    remain_q,  remain_d;
  logic                    expired_q, expired_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;

  logic                    tick_sel;
  state_e                  load_state;

  // Tick mux. Written as a compare loop so a select value with no matching
  // tick_i bit (out of range) simply yields no tick and the timer never expires.
  always_comb begin
    tick_sel = 1'b0;
    for (int i = 0; i < NUM_TB; i++) begin
      if (tb_sel_q == TB_SEL_WIDTH'(i)) begin
        tick_sel = tick_i[i];
      end
    end
  end

  // Where a start lands: zero delay expires immediately, otherwise ALIGN
  // decides whether the first selected tick is swallowed to align to the
  // time-base grid (N..N+1 periods) or counted (N-1..N periods).
  always_comb begin
    if (delay_i == '0) begin
      load_state = ST_DONE;
    end else if (ALIGN) begin
      load_state = ST_ARM;
    end else begin
      load_state = ST_RUN;
    end
  end

  always_comb begin
    state_d   = state_q;
    tb_sel_d  = tb_sel_q;
    remain_d  = remain_q;
    expired_d = expired_q;

    case (state_q)
      // DONE is a single cycle and otherwise behaves like IDLE, so a start
      // in the DONE cycle is taken as a fresh request.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (stop_i) begin
          expired_d = 1'b0;
        end else if (start_i) begin
          tb_sel_d  = tb_sel_i;
          remain_d  = delay_i;
          expired_d = 1'b0;
          state_d   = load_state;
        end
      end

      ST_ARM, ST_RUN: begin
        if (stop_i) begin
          state_d   = ST_IDLE;
          remain_d  = '0;
          expired_d = 1'b0;
        end else if (start_i) begin
          // Retrigger: reload everything; a tick in this cycle belongs to the
          // old request and is dropped.
          tb_sel_d  = tb_sel_i;
          remain_d  = delay_i;
          expired_d = 1'b0;
          state_d   = load_state;
        end else if (tick_sel) begin
          if (state_q == ST_ARM) begin
            state_d = ST_RUN;
          end else if (remain_q <= CNT_WIDTH'(1)) begin
            // Terminal tick; the <= also keeps remain from wrapping below 0.
            remain_d = '0;
            state_d  = ST_DONE;
          end else begin
            remain_d = remain_q - CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering DONE always raises the sticky flag, including a zero-delay start.
    if (state_d == ST_DONE) begin
      expired_d = 1'b1;
    end

    // Outputs are derived from the next state so they are registered yet
    // line up with the state they describe.
    busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      tb_sel_q  <= '0;
      remain_q  <= '0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tb_sel_q  <= tb_sel_d;
      remain_q  <= remain_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;
  assign remain_o  = remain_q;

endmodule : tick_delay_timer

// File: tb/tb_tick_delay_timer.sv
// Purpose : directed self-checking bench for tick_delay_timer (ALIGN=1 and ALIGN=0 instances).
// Latency : outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_tick_delay_timer;
  import tick_delay_timer_pkg::*;

  logic        clk;
  logic        nrst;
  logic [3:0]  tick_i;
  logic        start_i;
  logic        stop_i;
  logic [1:0]  tb_sel_i;
  logic [15:0] delay_i;

  // ALIGN=1 instance
  logic        busy, done, expired;
  logic [15:0] remain;
  // ALIGN=0 instance
  logic        a0_busy, a0_done, a0_expired;
  logic [15:0] a0_remain;

  int n_chk;
  int n_fail;

  tick_delay_timer #(.CNT_WIDTH(16), .NUM_TB(4), .TB_SEL_WIDTH(2), .ALIGN(1'b1)) u_dut (
    .clk(clk), .nrst(nrst), .tick_i(tick_i), .start_i(start_i), .stop_i(stop_i),
    .tb_sel_i(tb_sel_i), .delay_i(delay_i),
    .busy_o(busy), .done_o(done), .expired_o(expired), .remain_o(remain)
  );

  tick_delay_timer #(.CNT_WIDTH(16), .NUM_TB(4), .TB_SEL_WIDTH(2), .ALIGN(1'b0)) u_dut_a0 (
    .clk(clk), .nrst(nrst), .tick_i(tick_i), .start_i(start_i), .stop_i(stop_i),
    .tb_sel_i(tb_sel_i), .delay_i(delay_i),
    .busy_o(a0_busy), .done_o(a0_done), .expired_o(a0_expired), .remain_o(a0_remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sel, input logic [15:0] dly);
    tb_sel_i = sel;
    delay_i  = dly;
    start_i  = 1'b1;
    cyc();
    start_i  = 1'b0;
  endtask

  // One tick pulse followed by one idle cycle (ticks every 2 clk).
  task automatic tick_pulse(input logic [3:0] m);
    tick_i = m;
    cyc();
    tick_i = 4'b0;
    cyc();
  endtask

  initial begin
    logic seen;
    n_chk    = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    tick_i   = 4'b0;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    tb_sel_i = 2'd0;
    delay_i  = 16'd0;

    // Reset values
    #12;
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_expired", expired, 0);
    chk("rst_remain",  remain,  0);
    nrst = 1'b1;
    cyc();

    // ---- ALIGN=1, 1us base, delay 5: first tick discarded, done after 6th ----
    do_start(2'(TB_1US), 16'd5);
    chk("t1_busy",   busy,   1);
    chk("t1_remain", remain, 5);
    for (int k = 1; k <= 6; k++) begin
      tick_i = 4'b0001;
      cyc();
      tick_i = 4'b0;
      // ALIGN=0 instance counts the first tick, so it expires on the 5th
      chk("t1_a0_done", a0_done, (k == 5) ? 1 : 0);
      if (k < 6) begin
        chk("t1_remain_k", remain, 6 - k);
        chk("t1_done_early", done, 0);
      end
      if (k < 6) cyc();
    end
    chk("t1_done",    done,    1);
    chk("t1_busy_end", busy,   0);
    chk("t1_remain0", remain,  0);
    chk("t1_expired", expired, 1);
    cyc();
    chk("t1_done_pulse", done,    0);
    chk("t1_expired_st", expired, 1);

    // ---- ALIGN=0, delay 0: done next cycle, never busy ----
    do_start(2'(TB_1US), 16'd0);
    chk("t2_done",    a0_done,    1);
    chk("t2_busy",    a0_busy,    0);
    chk("t2_expired", a0_expired, 1);
    chk("t2_remain",  a0_remain,  0);
    cyc();
    chk("t2_done_off", a0_done, 0);
    chk("t2_busy_off", a0_busy, 0);

    // ---- start in the DONE cycle is a fresh start; expired clears ----
    do_start(2'(TB_1US), 16'd0);
    chk("t2b_done",    done,    1);
    chk("t2b_expired", expired, 1);
    do_start(2'(TB_1US), 16'd3);
    chk("t2b_exp_clr", expired, 0);
    chk("t2b_busy",    busy,    1);
    chk("t2b_remain",  remain,  3);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk("t2b_stopped", busy, 0);

    // ---- 1ms base selected, other ticks ignored ----
    do_start(2'(TB_1MS), 16'd3);
    for (int i = 0; i < 4; i++) tick_pulse((i % 2 != 0) ? 4'b0010 : 4'b1001);
    chk("t3_remain_hold", remain, 3);
    chk("t3_busy",        busy,   1);
    for (int k = 1; k <= 4; k++) begin
      tick_i = 4'b0100;
      cyc();
      tick_i = 4'b0;
      if (k < 4) chk("t3_remain_k", remain, 4 - k);
      chk("t3_done", done, (k == 4) ? 1 : 0);
      cyc();
    end

    // ---- stop after 4 counted ticks ----
    do_start(2'(TB_1US), 16'd10);
    for (int k = 0; k < 5; k++) tick_pulse(4'b0001);
    chk("t4_remain", remain, 6);
    stop_i = 1'b1;
    cyc();
    stop_i = 1'b0;
    chk("t4_busy",    busy,    0);
    chk("t4_remain0", remain,  0);
    chk("t4_expired", expired, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick_i = 4'b1111;
      cyc();
      tick_i = 4'b0;
      if (done) seen = 1'b1;
      cyc();
      if (done) seen = 1'b1;
    end
    chk("t4_no_done", seen, 0);

    // ---- retrigger at remain 2 with delay 7, coincident tick ignored ----
    do_start(2'(TB_1US), 16'd5);
    for (int k = 0; k < 4; k++) tick_pulse(4'b0001);
    chk("t5_remain2", remain, 2);
    tick_i = 4'b0001;
    do_start(2'(TB_1US), 16'd7);
    tick_i = 4'b0;
    chk("t5_reload", remain, 7);
    chk("t5_busy",   busy,   1);
    for (int k = 1; k <= 8; k++) begin
      tick_i = 4'b0001;
      cyc();
      tick_i = 4'b0;
      if (k == 7) begin
        chk("t5_remain1", remain, 1);
        chk("t5_no_done", done,   0);
      end
      if (k == 8) begin
        chk("t5_done",    done,   1);
        chk("t5_remain0", remain, 0);
      end
      cyc();
    end

    // ---- start+stop together in RUN: stop wins ----
    do_start(2'(TB_1US), 16'd5);
    tick_pulse(4'b0001);
    tick_pulse(4'b0001);
    chk("t6_run_remain", remain, 4);
    stop_i = 1'b1;
    do_start(2'(TB_1US), 16'd9);
    stop_i = 1'b0;
    chk("t6_busy",   busy,   0);
    chk("t6_remain", remain, 0);

    // ---- reset mid-RUN ----
    do_start(2'(TB_1US), 16'd5);
    tick_pulse(4'b0001);
    tick_pulse(4'b0001);
    chk("t7_busy_pre", busy, 1);
    nrst = 1'b0;
    #2;
    chk("t7_busy",    busy,    0);
    chk("t7_done",    done,    0);
    chk("t7_expired", expired, 0);
    chk("t7_remain",  remain,  0);
    cyc();
    nrst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_i = 4'b0001;
      cyc();
      tick_i = 4'b0;
      if (done || busy) seen = 1'b1;
      cyc();
    end
    chk("t7_quiet", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_tick_delay_timer
